// File: rtl/fu_issue_scheduler_pkg.sv
// Shared types for the FU issue scheduler: lane FSM encoding and perf counter width.
package rv32i_types;

    typedef enum logic [1:0] {
        LANE_IDLE,
        LANE_MUL_START,
        LANE_MUL_WAIT,
        LANE_DRAIN
    } fu_lane_state_t;

    localparam int FU_PERF_CNT_W = 32;

endpackage

// File: rtl/rr_multi_picker.sv
// Rotating multi-pick arbiter: selects up to `limit` set bits of req, scanning
// upward from ptr with wrap, and reports each pick in scan order.
module rr_multi_picker #(
    parameter int N  = 8,
    parameter int SS = 2,
    parameter int IW = $clog2(N),
    parameter int CW = $clog2(SS + 1)
) (
    input  logic [N-1:0]           req,
    input  logic [IW-1:0]          ptr,
    input  logic [CW-1:0]          limit,
    output logic [N-1:0]           grant,
    output logic [SS-1:0][IW-1:0]  pick_idx,
    output logic [SS-1:0]          pick_valid,
    output logic [IW-1:0]          last_idx
);

    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    // N is a power of two, so the IW-bit add wraps the scan for free.
    always_comb begin
        grant      = '0;
        pick_idx   = '0;
        pick_valid = '0;
        last_idx   = ptr;
        idx        = '0;
        cnt        = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + IW'(i);
            if (req[idx] && (cnt < limit)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < SS; k++) begin
                    if (cnt == CW'(k)) begin
                        pick_idx[k]   = idx;
                        pick_valid[k] = 1'b1;
                    end
                end
                last_idx = idx;
                cnt      = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler binding ready RS entries round-robin onto SS FU lanes.
// Optional perf counters enabled by FU_SCHED_PERF_CNT_EN.
module fu_issue_scheduler
    import rv32i_types::*;
#(
    parameter int SS      = 2,
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [RS_SIZE-1:0]    req_valid,
    input  logic [RS_SIZE-1:0]    req_is_mul,
    output logic [RS_SIZE-1:0]    grant,
    output logic [SS-1:0]         lane_valid,
    output logic [SS*IDX_W-1:0]   lane_idx,
    output logic [SS-1:0]         lane_start,
    input  logic [SS-1:0]         mult_done,
    output logic [SS-1:0]         lane_wb,
    output logic [SS-1:0]         lane_busy
`ifdef FU_SCHED_PERF_CNT_EN
    ,output logic [FU_PERF_CNT_W-1:0] perf_issued
    ,output logic [FU_PERF_CNT_W-1:0] perf_mul_stall
`endif
);

    localparam int CW = $clog2(SS + 1);

    logic [IDX_W-1:0]          rr_ptr;
    logic [SS-1:0]             idle;
    logic [CW-1:0]             n_free;
    logic [CW-1:0]             limit;
    logic [CW-1:0]             rank;
    logic [SS-1:0][IDX_W-1:0]  pick_idx;
    logic [SS-1:0]             pick_valid;
    logic [IDX_W-1:0]          last_idx;
    logic [SS-1:0]             bind_valid;
    logic [SS-1:0][IDX_W-1:0]  bind_idx;

    always_comb begin
        n_free = '0;
        for (int l = 0; l < SS; l++) n_free = n_free + CW'(idle[l]);
        limit = (rst || flush) ? '0 : n_free;
    end

    rr_multi_picker #(.N(RS_SIZE), .SS(SS), .IW(IDX_W), .CW(CW)) u_picker (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .limit      (limit),
        .grant      (grant),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid),
        .last_idx   (last_idx)
    );

    // k-th pick goes to the k-th idle lane in ascending lane order.
    always_comb begin
        rank       = '0;
        bind_valid = '0;
        bind_idx   = '0;
        for (int l = 0; l < SS; l++) begin
            if (idle[l]) begin
                for (int k = 0; k < SS; k++) begin
                    if (rank == CW'(k)) begin
                        bind_valid[l] = pick_valid[k];
                        bind_idx[l]   = pick_idx[k];
                    end
                end
                rank = rank + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush)  rr_ptr <= '0;
        else if (|grant)   rr_ptr <= last_idx + IDX_W'(1);
    end

    for (genvar g = 0; g < SS; g++) begin : g_lane
        fu_lane_state_t   st;
        logic             vld;
        logic             start;
        logic             wb;
        logic [IDX_W-1:0] idx;
        logic             bind_mul;

        assign bind_mul = req_is_mul[bind_idx[g]];

        always_ff @(posedge clk) begin
            if (rst) begin
                st    <= LANE_IDLE;
                vld   <= 1'b0;
                start <= 1'b0;
                wb    <= 1'b0;
                idx   <= '0;
            end else begin
                vld   <= 1'b0;
                start <= 1'b0;
                wb    <= 1'b0;
                if (flush) begin
                    // An in-flight multiply must still run to completion before reuse.
                    case (st)
                        LANE_MUL_START,
                        LANE_MUL_WAIT: st <= mult_done[g] ? LANE_IDLE : LANE_DRAIN;
                        LANE_DRAIN:    if (mult_done[g]) st <= LANE_IDLE;
                        default:       st <= LANE_IDLE;
                    endcase
                end else begin
                    case (st)
                        LANE_IDLE: begin
                            if (bind_valid[g]) begin
                                vld <= 1'b1;
                                idx <= bind_idx[g];
                                if (bind_mul) begin
                                    st    <= LANE_MUL_START;
                                    start <= 1'b1;
                                end else begin
                                    wb <= 1'b1;
                                end
                            end
                        end
                        LANE_MUL_START: begin
                            vld <= 1'b1;
                            st  <= LANE_MUL_WAIT;
                        end
                        LANE_MUL_WAIT: begin
                            vld <= 1'b1;
                            if (mult_done[g]) begin
                                wb <= 1'b1;
                                st <= LANE_IDLE;
                            end
                        end
                        LANE_DRAIN: if (mult_done[g]) st <= LANE_IDLE;
                        default:    st <= LANE_IDLE;
                    endcase
                end
            end
        end

        assign idle[g]                     = (st == LANE_IDLE);
        assign lane_busy[g]                = (st != LANE_IDLE);
        assign lane_valid[g]               = vld;
        assign lane_start[g]               = start;
        assign lane_wb[g]                  = wb;
        assign lane_idx[g*IDX_W +: IDX_W]  = idx;
    end

`ifdef FU_SCHED_PERF_CNT_EN
    logic [SS-1:0] mul_blocked;

    for (genvar g = 0; g < SS; g++) begin : g_blk
        assign mul_blocked[g] = (g_lane[g].st == LANE_MUL_WAIT) || (g_lane[g].st == LANE_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued    <= '0;
            perf_mul_stall <= '0;
        end else begin
            perf_issued <= perf_issued + FU_PERF_CNT_W'($countones(grant));
            if ((|req_valid) && (grant == '0) && (|mul_blocked))
                perf_mul_stall <= perf_mul_stall + FU_PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
- Issue scheduler between the reservation station and the SS functional-unit lanes (ALU/CMP/shift-add multiplier per lane).
- Each cycle, selects up to SS ready entries round-robin, binds each to a free lane, and pulses the multiplier start.
- Holds a lane while its multi-cycle multiply is in flight; handles flush by draining in-flight multiplies.

Parameters:
- SS, 2, number of FU lanes.
- RS_SIZE, 8, reservation-station entries (requesters); power of 2.
- IDX_W, $clog2(RS_SIZE), entry index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (mispredict); kills all non-draining lane state.
- req_valid  in  RS_SIZE  entry i ready to issue.
- req_is_mul  in  RS_SIZE  entry i is a multiply.
- grant  out  RS_SIZE  combinational; entry i issued this cycle; requester clears req_valid[i] next cycle.
- lane_valid  out  SS  registered; lane holds a live instruction.
- lane_idx  out  SS*IDX_W  registered RS index bound to each lane.
- lane_start  out  SS  registered one-cycle multiplier start pulse.
- mult_done  in  SS  multiplier done per lane.
- lane_wb  out  SS  registered; lane result valid for writeback this cycle.
- lane_busy  out  SS  lane not in IDLE.

Behaviour:
- Reset:
  - All lanes IDLE; rr_ptr=0.
  - lane_valid, lane_idx, lane_start, lane_wb, lane_busy = 0; grant = 0.
- Lane FSM, one per lane:
  - IDLE: lane eligible for a grant.
    - ALU grant: lane_valid=1, lane_wb=1 next cycle for one cycle; stay IDLE.
    - MUL grant: go to MUL_START.
  - MUL_START (1 cycle): lane_start=1, lane_valid=1; go to MUL_WAIT.
  - MUL_WAIT: lane_valid=1; lane_idx held stable.
    - mult_done=1: lane_wb=1 that cycle's next edge; go to IDLE.
  - DRAIN: lane_valid=0, lane_busy=1, lane_wb suppressed.
    - mult_done=1: go to IDLE.
- Arbitration (combinational):
  - Scan entries from rr_ptr upward, wrapping modulo RS_SIZE.
  - Assign requesting entries to IDLE lanes in ascending lane order.
  - At most SS grants per cycle; each entry granted at most once.
- Pointer update: rr_ptr <= (last granted index + 1) mod RS_SIZE; unchanged if no grant.
- Latency:
  - Grant in cycle N gives lane_valid/lane_idx at N+1.
  - ALU: lane_wb at N+1.
  - MUL: lane_start at N+1; lane_wb the cycle after mult_done is sampled.
- Lane eligibility: only lanes in IDLE at the start of a cycle are eligible. A lane finishing MUL_WAIT is eligible from the following cycle.
- Flush:
  - grant forced 0 that cycle; lane_wb and lane_valid cleared next cycle.
  - MUL_START or MUL_WAIT lanes go to DRAIN, unless mult_done is simultaneously 1, then IDLE with no wb.
  - IDLE lanes stay IDLE; rr_ptr reset to 0.
- Simultaneous flush and rst: rst wins.
- rst mid-multiply: FSM to IDLE immediately. Multiplier is reset by the same rst, so no drain is needed.
- All lanes busy: grant=0; requests wait, no starvation reordering beyond round-robin.
- No requests: lanes idle, outputs low except held lane_idx.

Optional Feature:
- Macro: FU_SCHED_PERF_CNT_EN.
- Enabled: adds 32-bit outputs perf_issued (total grants, adds popcount per cycle) and perf_mul_stall. perf_mul_stall counts cycles with req_valid!=0 and zero grants while at least one lane is in MUL_WAIT or DRAIN. Both counters wrap, reset to 0 on rst, and are unaffected by flush.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv32i_types package gets:
  - typedef enum fu_lane_state_t {LANE_IDLE, LANE_MUL_START, LANE_MUL_WAIT, LANE_DRAIN};
  - constant FU_PERF_CNT_W=32.
- Sub-module rr_multi_picker: combinational rotate-and-select of up to SS set bits starting at a pointer. Returns grant vector, per-pick index and valid, and last index. Instantiated once.

Test Plan:
- Round-robin: SS=2, rr_ptr=0, req_valid=8'b0000_1111 (all ALU) -> cycle0 grant=0000_0011; lane_idx={1,0} and lane_wb=2'b11 next cycle. Requester clears bits, cycle1 grant=0000_1100; rr_ptr=4.
- Pointer wrap: rr_ptr=6, req_valid=8'b1100_0001 -> grant=1100_0000, rr_ptr=0. Next cycle entry 0 is granted.
- Multiply hold: grant mul entry 3 to lane0 -> lane_start[0]=1 for exactly one cycle at N+1. Lane0 stays busy; ALU entries issue only on lane1. mult_done[0] at N+5 -> lane_wb[0]=1 at N+6; lane0 granted again at N+6.
- Flush during multiply: lane0 in MUL_WAIT, flush=1 -> lane0 DRAIN, lane_valid[0]=0, grant=0. mult_done[0] 3 cycles later -> no lane_wb; lane0 IDLE the next cycle.
- Flush coincident with mult_done -> lane IDLE next cycle, lane_wb=0. Also: rst asserted mid-MUL_WAIT -> all outputs 0 next cycle.
- Saturation: both lanes in MUL_WAIT, req_valid=8'hFF for 4 cycles -> grant=0 throughout. With FU_SCHED_PERF_CNT_EN, perf_mul_stall increments by 4 and perf_issued is unchanged.
